// File: rtl/execute_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execute_pkg
// Purpose  : Shared itype codes, funct3/funct7 opcodes, FSM state encodings
//            and small helper functions for the execute stage.
// Revision : 1.0  initial release
// ============================================================================
package execute_pkg;

  // Instruction class codes delivered by decode on itype_i
  localparam logic [4:0] RTYPE = 5'b00001;
  localparam logic [4:0] ITYPE = 5'b00010;
  localparam logic [4:0] STYPE = 5'b00100;
  localparam logic [4:0] UTYPE = 5'b01000;

  // funct3 opcodes for RTYPE/ITYPE arithmetic
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 values; bit 5 (instruction bit 30) selects SUB/SRA
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Execute FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Sign-extend a 12-bit immediate to 32 bits
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // One-bit shift step; arithmetic right shifts replicate bit 31
  function automatic logic [31:0] shift_step(input logic [31:0] v,
                                             input logic        left,
                                             input logic        arith);
    return left ? {v[30:0], 1'b0} : {arith & v[31], v[31:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_if.sv
`default_nettype none
// ============================================================================
// Module   : execute_if
// Purpose  : Decode-to-execute handshake, write-back and store bus.
// Revision : 1.0  initial release
// ============================================================================
interface execute_if;
  logic [31:0] ra_i;
  logic [31:0] rb_i;
  logic [31:0] pass_i;
  logic [4:0]  itype_i;
  logic [31:0] ir_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] wd_o;
  logic        wd_q_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic        illegal_o;

  // Decode side
  modport master (
    output ra_i, rb_i, pass_i, itype_i, ir_i, valid_i,
    input  ready_o, wd_o, wd_q_o, mem_addr_o, mem_wdata_o, mem_we_o, illegal_o
  );

  // Execute side
  modport slave (
    input  ra_i, rb_i, pass_i, itype_i, ir_i, valid_i,
    output ready_o, wd_o, wd_q_o, mem_addr_o, mem_wdata_o, mem_we_o, illegal_o
  );
endinterface
`default_nettype wire

// File: rtl/execute_shift.sv
`default_nettype none
// ============================================================================
// Module   : exec_shift
// Purpose  : Iterative one-bit-per-cycle shifter. The first bit moves on the
//            start edge, so an N-bit shift raises done N cycles after start.
// Revision : 1.0  initial release
// ============================================================================
module exec_shift
  import execute_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        start,
  input  wire logic [4:0]  amount,
  input  wire logic        direction,
  input  wire logic        arith,
  input  wire logic [31:0] operand,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result
);

  logic [4:0]  r_count;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_dir;
  logic        r_arith;

  // Load on start (performing the first step), then step until count expires
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_dir    <= 1'b0;
      r_arith  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start && (amount != 5'd0)) begin
        r_dir    <= direction;
        r_arith  <= arith;
        r_result <= shift_step(operand, direction, arith);
        r_count  <= amount - 5'd1;
        r_busy   <= (amount > 5'd1);
        r_done   <= (amount == 5'd1);
      end else if (r_busy) begin
        r_result <= shift_step(r_result, r_dir, r_arith);
        r_count  <= r_count - 5'd1;
        if (r_count == 5'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: rtl/execute.sv
`default_nettype none
// ============================================================================
// Module   : execute
// Purpose  : Multi-cycle execute stage: ALU ops, iterative shifts, upper
//            immediates and stores, with a valid/ready handshake to decode.
// Revision : 1.0  initial release
// ============================================================================
module execute
  import execute_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  reset,
  execute_if.slave   bus
);

  logic [1:0]  r_state;
  logic [31:0] r_ra;
  logic [31:0] r_rb;
  logic [31:0] r_pass;
  logic [4:0]  r_itype;
  logic [31:0] r_ir;
  logic [31:0] r_wd;
  logic        r_wd_q;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_ill;

  logic [2:0]  w_f3;
  logic [4:0]  w_rd;
  logic        w_alt;
  logic        w_is_alu;
  logic [31:0] w_opb;
  logic        w_sub;
  logic [4:0]  w_shamt;
  logic        w_is_shift;
  logic        w_sh_start;
  logic        w_sh_busy;
  logic        w_sh_done;
  logic [31:0] w_sh_result;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic        w_unused_ir;

  assign w_f3       = r_ir[14:12];
  assign w_rd       = r_ir[11:7];
  assign w_alt      = r_ir[30];
  assign w_is_alu   = (r_itype == RTYPE) || (r_itype == ITYPE);
  // I-type immediates arrive zero-extended; restore their sign here
  assign w_opb      = (r_itype == ITYPE) ? sext12(r_rb[11:0]) : r_rb;
  assign w_sub      = (r_itype == RTYPE) && w_alt;
  assign w_shamt    = w_opb[4:0];
  assign w_is_shift = w_is_alu && ((w_f3 == F3_SLL) || (w_f3 == F3_SR));
  assign w_sh_start = (r_state == ST_EXEC) && w_is_shift && (w_shamt != 5'd0);
  // Only funct3, rd and bit 30 of the instruction word influence execution
  assign w_unused_ir = ^{r_ir[31], r_ir[29:15], r_ir[6:0]};

  exec_shift u_shift (
    .clk       (clk),
    .reset     (reset),
    .start     (w_sh_start),
    .amount    (w_shamt),
    .direction (w_f3 == F3_SLL),
    .arith     (w_alt),
    .operand   (r_ra),
    .busy      (w_sh_busy),
    .done      (w_sh_done),
    .result    (w_sh_result)
  );

  // Single-cycle ALU; shift opcodes pass A through for a zero shift amount
  always_comb begin
    w_alu = '0;
    case (w_f3)
      F3_ADD:  w_alu = w_sub ? (r_ra - w_opb) : (r_ra + w_opb);
      F3_SLL:  w_alu = r_ra;
      F3_SLT:  w_alu = {31'd0, $signed(r_ra) < $signed(w_opb)};
      F3_SLTU: w_alu = {31'd0, r_ra < w_opb};
      F3_XOR:  w_alu = r_ra ^ w_opb;
      F3_SR:   w_alu = r_ra;
      F3_OR:   w_alu = r_ra | w_opb;
      F3_AND:  w_alu = r_ra & w_opb;
      default: w_alu = '0;
    endcase
  end

  // Write-back value for single-cycle results
  always_comb begin
    w_result = w_alu;
    if (r_itype == UTYPE) w_result = {r_pass[19:0], 12'd0};
  end

  // Control FSM; strobes default low so each is a one-cycle pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_pass  <= '0;
      r_itype <= '0;
      r_ir    <= '0;
      r_wd    <= '0;
      r_wd_q  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_wd_q <= 1'b0;
      r_we   <= 1'b0;
      r_ill  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.valid_i) begin
            r_ra    <= bus.ra_i;
            r_rb    <= bus.rb_i;
            r_pass  <= bus.pass_i;
            r_itype <= bus.itype_i;
            r_ir    <= bus.ir_i;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (w_sh_start) begin
            r_state <= ST_SHIFT;
          end else if (w_is_alu || (r_itype == UTYPE)) begin
            r_wd    <= w_result;
            r_wd_q  <= (w_rd != 5'd0);
            r_state <= ST_DONE;
          end else if (r_itype == STYPE) begin
            r_addr  <= sext12(r_ra[11:0]) + r_rb;
            r_wdata <= r_pass;
            r_we    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_ill   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (w_sh_done) begin
            r_wd    <= w_sh_result;
            r_wd_q  <= (w_rd != 5'd0);
            r_state <= ST_DONE;
          end else if (!w_sh_busy) begin
            // Shifter idle without completing: recover rather than hang
            r_state <= ST_IDLE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_o     = (r_state == ST_IDLE);
  assign bus.wd_o        = r_wd;
  assign bus.wd_q_o      = r_wd_q;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.mem_we_o    = r_we;
  assign bus.illegal_o   = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute
// Purpose  : Scoreboard bench for the execute stage with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_execute;
  import execute_pkg::*;

  localparam int K_WB   = 0;
  localparam int K_ST   = 1;
  localparam int K_ILL  = 2;
  localparam int K_NONE = 3;

  typedef struct {
    int          kind;
    logic [31:0] d;
    logic [31:0] a;
    int          acc;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  execute_if bus_if ();

  execute u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk_ir(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, 7'b0110011};
  endfunction

  // Pop the oldest expectation and compare it against the strobe just seen
  task automatic check_evt(input int kind);
    exp_t        e;
    int          lat;
    logic        ok;
    logic [31:0] got_d;
    logic [31:0] got_a;
    got_d = (kind == K_ST) ? bus_if.mem_wdata_o : bus_if.wd_o;
    got_a = bus_if.mem_addr_o;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe: kind=%0d d=%h at cycle %0d, required no strobe",
               kind, got_d, cyc);
    end else begin
      e   = sbq.pop_front();
      lat = cyc - e.acc;
      ok  = (e.kind == kind) && (lat == e.lat);
      if (kind == K_WB) ok = ok && (got_d == e.d);
      if (kind == K_ST) ok = ok && (got_d == e.d) && (got_a == e.a);
      if (!ok) begin
        errors++;
        $display("FAIL strobe: kind=%0d lat=%0d d=%h a=%h, required kind=%0d lat=%0d d=%h a=%h",
                 kind, lat, got_d, got_a, e.kind, e.lat, e.d, e.a);
      end
    end
  endtask

  // Monitor: every output strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (bus_if.wd_q_o)    check_evt(K_WB);
      if (bus_if.mem_we_o)  check_evt(K_ST);
      if (bus_if.illegal_o) check_evt(K_ILL);
    end
  end

  // Issue one instruction (called at a negedge) and wait for the block to free up
  task automatic issue(input logic [4:0] it, input logic [31:0] ra, input logic [31:0] rb,
                       input logic [31:0] pass, input logic [31:0] ir, input int kind,
                       input logic [31:0] ed, input logic [31:0] ea, input int lat,
                       input string name);
    int w;
    int busy;
    int exp_busy;
    exp_t e;
    w = 0;
    while (!bus_if.ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    bus_if.itype_i = it;
    bus_if.ra_i    = ra;
    bus_if.rb_i    = rb;
    bus_if.pass_i  = pass;
    bus_if.ir_i    = ir;
    bus_if.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.valid_i = 1'b0;
    bus_if.ra_i    = 32'hA5A5_A5A5;
    bus_if.rb_i    = 32'h5A5A_5A5A;
    bus_if.pass_i  = 32'h0F0F_0F0F;
    bus_if.ir_i    = 32'hFFFF_FFFF;
    if (kind != K_NONE) begin
      e.kind = kind; e.d = ed; e.a = ea; e.acc = cyc; e.lat = lat;
      sbq.push_back(e);
    end
    busy = 0;
    while (!bus_if.ready_o && busy < 200) begin
      busy++;
      @(negedge clk);
    end
    exp_busy = (kind == K_ILL) ? 1 : lat + 1;
    checks++;
    if (busy != exp_busy) begin
      errors++;
      $display("FAIL %s_busy: ready low %0d cycles, required %0d", name, busy, exp_busy);
    end
    if (kind == K_NONE) begin
      checks++;
      if (bus_if.wd_o !== ed) begin
        errors++;
        $display("FAIL %s_wd: wd_o=%h, required %h", name, bus_if.wd_o, ed);
      end
    end
  endtask

  initial begin
    bus_if.valid_i = 1'b0;
    bus_if.ra_i    = '0;
    bus_if.rb_i    = '0;
    bus_if.pass_i  = '0;
    bus_if.ir_i    = '0;
    bus_if.itype_i = '0;
    #3;
    checks++;
    if ({bus_if.ready_o, bus_if.wd_o, bus_if.mem_addr_o, bus_if.mem_wdata_o,
         bus_if.wd_q_o, bus_if.mem_we_o, bus_if.illegal_o} !== {1'b1, 96'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset_state: ready=%b wd=%h addr=%h wdata=%h strobes=%b%b%b, required ready=1 rest 0",
               bus_if.ready_o, bus_if.wd_o, bus_if.mem_addr_o, bus_if.mem_wdata_o,
               bus_if.wd_q_o, bus_if.mem_we_o, bus_if.illegal_o);
    end
    @(negedge clk);
    reset = 1'b1;

    issue(RTYPE, 32'h7FFF_FFFF, 32'h1, 32'h0, mk_ir(F7_BASE, F3_ADD, 5'd5), K_WB, 32'h8000_0000, 0, 1, "add_ovf");
    issue(RTYPE, 32'h5, 32'h7, 32'h0, mk_ir(F7_ALT, F3_ADD, 5'd6), K_WB, 32'hFFFF_FFFE, 0, 1, "sub");
    issue(ITYPE, 32'h8000_0000, 32'h41F, 32'h0, mk_ir(F7_ALT, F3_SR, 5'd3), K_WB, 32'hFFFF_FFFF, 0, 32, "srai31");
    issue(ITYPE, 32'h5, 32'hFFF, 32'h0, mk_ir(7'h7F, F3_ADD, 5'd1), K_WB, 32'h4, 0, 1, "addi_neg");
    issue(RTYPE, 32'hFFFF_FFFF, 32'h1, 32'h0, mk_ir(F7_BASE, F3_SLT, 5'd2), K_WB, 32'h1, 0, 1, "slt");
    issue(RTYPE, 32'hFFFF_FFFF, 32'h1, 32'h0, mk_ir(F7_BASE, F3_SLTU, 5'd2), K_WB, 32'h0, 0, 1, "sltu");
    issue(ITYPE, 32'h5, 32'h800, 32'h0, mk_ir(F7_BASE, F3_SLT, 5'd2), K_WB, 32'h0, 0, 1, "slti");
    issue(ITYPE, 32'h5, 32'h800, 32'h0, mk_ir(F7_BASE, F3_SLTU, 5'd2), K_WB, 32'h1, 0, 1, "sltiu");
    issue(RTYPE, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, mk_ir(F7_BASE, F3_XOR, 5'd9), K_WB, 32'h0FF0_0FF0, 0, 1, "xor");
    issue(RTYPE, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, mk_ir(F7_BASE, F3_OR, 5'd9), K_WB, 32'hFFF0_FFF0, 0, 1, "or");
    issue(RTYPE, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, mk_ir(F7_BASE, F3_AND, 5'd9), K_WB, 32'hF000_F000, 0, 1, "and");
    issue(RTYPE, 32'h1, 32'h4, 32'h0, mk_ir(F7_BASE, F3_SLL, 5'd7), K_WB, 32'h10, 0, 5, "sll4");
    issue(RTYPE, 32'h8000_0000, 32'h21, 32'h0, mk_ir(F7_BASE, F3_SR, 5'd7), K_WB, 32'h4000_0000, 0, 2, "srl1");
    issue(RTYPE, 32'h8000_0000, 32'h4, 32'h0, mk_ir(F7_ALT, F3_SR, 5'd7), K_WB, 32'hF800_0000, 0, 5, "sra4");
    issue(ITYPE, 32'h1234, 32'h0, 32'h0, mk_ir(F7_BASE, F3_SR, 5'd8), K_WB, 32'h1234, 0, 1, "srli0");
    issue(STYPE, 32'h4, 32'h1000, 32'hDEAD_BEEF, mk_ir(F7_BASE, 3'b010, 5'd7), K_ST, 32'hDEAD_BEEF, 32'h1004, 1, "store");
    issue(STYPE, 32'hFFC, 32'h1000, 32'h0, mk_ir(F7_BASE, 3'b010, 5'd7), K_ST, 32'h0, 32'h0FFC, 1, "store_neg");
    issue(UTYPE, 32'h0, 32'h0, 32'h12345, mk_ir(F7_BASE, 3'b000, 5'd0), K_NONE, 32'h1234_5000, 0, 1, "lui_rd0");
    issue(UTYPE, 32'h0, 32'h0, 32'hFFFFF, mk_ir(F7_BASE, 3'b000, 5'd2), K_WB, 32'hFFFF_F000, 0, 1, "lui");
    issue(RTYPE, 32'h2, 32'h3, 32'h0, mk_ir(F7_BASE, F3_ADD, 5'd0), K_NONE, 32'h5, 0, 1, "add_rd0");
    issue(5'b11111, 32'h1, 32'h1, 32'h0, mk_ir(F7_BASE, F3_ADD, 5'd4), K_ILL, 0, 0, 1, "illegal");
    issue(STYPE, 32'h8, 32'h2000, 32'hCAFE_F00D, mk_ir(F7_BASE, 3'b010, 5'd7), K_ST, 32'hCAFE_F00D, 32'h2008, 1, "store2");

    // Reset in the middle of a 20-bit shift: no strobe may follow
    bus_if.itype_i = RTYPE;
    bus_if.ra_i    = 32'h1;
    bus_if.rb_i    = 32'd20;
    bus_if.pass_i  = 32'h0;
    bus_if.ir_i    = mk_ir(F7_BASE, F3_SLL, 5'd4);
    bus_if.valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.valid_i = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_if.ready_o, bus_if.wd_o, bus_if.mem_addr_o, bus_if.mem_wdata_o,
         bus_if.wd_q_o, bus_if.mem_we_o, bus_if.illegal_o} !== {1'b1, 96'd0, 3'd0}) begin
      errors++;
      $display("FAIL mid_shift_reset: ready=%b wd=%h addr=%h wdata=%h strobes=%b%b%b, required ready=1 rest 0",
               bus_if.ready_o, bus_if.wd_o, bus_if.mem_addr_o, bus_if.mem_wdata_o,
               bus_if.wd_q_o, bus_if.mem_we_o, bus_if.illegal_o);
    end
    @(negedge clk);
    reset = 1'b1;
    issue(RTYPE, 32'h10, 32'h20, 32'h0, mk_ir(F7_BASE, F3_ADD, 5'd11), K_WB, 32'h30, 0, 1, "add_after_reset");
    repeat (30) @(negedge clk);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL missing_strobes: %0d expected strobes never seen, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
